// File: rtl/pipe_hazard_pkg.sv
// ============================================================================
// Module      : pipe_hazard_pkg
// Description : Shared types and constants for the pipeline stall controller.
//               Holds the controller state encoding, the "never hazards"
//               register number and the stall-length table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_hazard_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Register 0 is hard-wired to zero, so it can never create a hazard.
    localparam int REG_ZERO   = 0;

    // Stall lengths in cycles.
    localparam int STALL_EX   = 2;  // producer in EX, no bypass network
    localparam int STALL_MEM  = 1;  // producer in MEM, no bypass network
    localparam int STALL_LOAD = 1;  // load-use with bypass network present

endpackage : pipe_hazard_pkg

`default_nettype wire

// File: rtl/hazard_match.sv
// ============================================================================
// Module      : hazard_match
// Description : Combinational compare of the ID-stage source registers against
//               the EX- and MEM-stage destination registers.
//   id_src1, id_src2 : ID source register numbers
//   id_rd_act        : ID instruction actually reads its sources
//   ex_dest, ex_wr   : EX destination register and its write enable
//   mem_dest, mem_wr : MEM destination register and its write enable
//   hit_ex           : a live ID source matches the EX destination
//   hit_mem          : a live ID source matches the MEM destination
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_match
    import pipe_hazard_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_rd_act,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_wr,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wr,
    output logic             hit_ex,
    output logic             hit_mem
);

    localparam logic [REG_W-1:0] C_ZERO = REG_W'(REG_ZERO);

    logic w_src1Live;
    logic w_src2Live;

    // A source only matters if the instruction reads it and it is not r0.
    assign w_src1Live = id_rd_act && (id_src1 != C_ZERO);
    assign w_src2Live = id_rd_act && (id_src2 != C_ZERO);

    assign hit_ex  = ex_wr  && ((w_src1Live && (id_src1 == ex_dest)) ||
                                (w_src2Live && (id_src2 == ex_dest)));
    assign hit_mem = mem_wr && ((w_src1Live && (id_src1 == mem_dest)) ||
                                (w_src2Live && (id_src2 == mem_dest)));

endmodule : hazard_match

`default_nettype wire

// File: rtl/pipe_stall_controller.sv
// ============================================================================
// Module      : pipe_stall_controller
// Description : Hold/bubble/flush sequencer for the 5-stage pipeline. Detects
//               RAW hazards between ID sources and EX/MEM destinations, holds
//               PC and IF/ID for the required number of cycles, and squashes
//               IF/ID and ID/EX on a taken branch.
//   Inputs : clk, rst_n (async, active low), id_src1/2, id_rd_act, ex_dest,
//            ex_wr, ex_is_load, mem_dest, mem_wr, br_taken, perf_clr
//   Outputs: pc_we, ifid_we, idex_bubble, ifid_flush, stall_cycles
//   Build option: FORWARDING_EN - a bypass network exists, so only a load-use
//            hit on EX stalls (one cycle); otherwise the full stall table is used.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stall_controller
    import pipe_hazard_pkg::*;
#(
    parameter int REG_W  = 4,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic              id_rd_act,
    input  logic [REG_W-1:0]  ex_dest,
    input  logic              ex_wr,
    input  logic              ex_is_load,
    input  logic [REG_W-1:0]  mem_dest,
    input  logic              mem_wr,
    input  logic              br_taken,
    input  logic              perf_clr,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic [PERF_W-1:0] stall_cycles
);

    state_t              r_state;
    state_t              w_nextState;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_nextCnt;
    logic [CNT_W-1:0]    w_need;
    logic [CNT_W-1:0]    w_needRem;
    logic [PERF_W-1:0]   r_stallCycles;
    logic                w_hitEx;
    logic                w_hitMem;

    hazard_match #(
        .REG_W (REG_W)
    ) u_hazard_match (
        .id_src1   (id_src1),
        .id_src2   (id_src2),
        .id_rd_act (id_rd_act),
        .ex_dest   (ex_dest),
        .ex_wr     (ex_wr),
        .mem_dest  (mem_dest),
        .mem_wr    (mem_wr),
        .hit_ex    (w_hitEx),
        .hit_mem   (w_hitMem)
    );

`ifdef FORWARDING_EN
    // Bypass covers everything except a load whose data is not back yet.
    logic w_unused_mem;
    assign w_unused_mem = w_hitMem;
    assign w_need = (w_hitEx && ex_is_load) ? CNT_W'(STALL_LOAD) : '0;
`else
    // No bypass: wait until the producer has reached WB (written first half).
    logic w_unused_load;
    assign w_unused_load = ex_is_load;
    assign w_need = w_hitEx  ? CNT_W'(STALL_EX)  :
                    w_hitMem ? CNT_W'(STALL_MEM) : '0;
`endif

    // Cycles still to hold after the detecting cycle itself.
    assign w_needRem = w_need - CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;

        case (r_state)
            RUN: begin
                if (br_taken) begin
                    // Branch wins: the hazarding ID instruction is squashed anyway.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    w_nextState = FLUSH;
                end else if (w_need != '0) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    w_nextCnt   = w_needRem;
                    w_nextState = (w_needRem != '0) ? STALL : RUN;
                end
            end
            STALL: begin
                // Hazard inputs are not re-examined; the count alone decides.
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                if (r_cnt <= CNT_W'(1)) begin
                    w_nextCnt   = '0;
                    w_nextState = RUN;
                end else begin
                    w_nextCnt   = r_cnt - CNT_W'(1);
                end
            end
            FLUSH: begin
                // ID holds the squashed slot, so hazard detection is masked.
                w_nextState = RUN;
            end
            default: begin
                w_nextState = RUN;
                w_nextCnt   = '0;
            end
        endcase

        // Hold the pipeline quiet while reset is asserted.
        if (!rst_n) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b0;
        end
    end

    // Saturating count of held-PC cycles; clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCycles <= '0;
        end else if (perf_clr) begin
            r_stallCycles <= '0;
        end else if (!pc_we && (r_stallCycles != {PERF_W{1'b1}})) begin
            r_stallCycles <= r_stallCycles + PERF_W'(1);
        end
    end

    assign stall_cycles = r_stallCycles;

    // EX holds a bubble while stalling, so a taken branch there is impossible.
    a_noBranchInStall: assert property (@(posedge clk) disable iff (!rst_n)
        !((r_state == STALL) && br_taken));

endmodule : pipe_stall_controller

`default_nettype wire

// File: tb/tb_pipe_stall_controller.sv
// ============================================================================
// Module      : tb_pipe_stall_controller
// Description : Directed self-checking bench for pipe_stall_controller.
//               Output bundle checked as {pc_we, ifid_we, idex_bubble, ifid_flush}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stall_controller;

    localparam int REG_W  = 4;
    localparam int CNT_W  = 2;
    localparam int PERF_W = 16;

    localparam logic [3:0] C_RUN   = 4'b1100;  // normal flow
    localparam logic [3:0] C_HOLD  = 4'b0010;  // stall / reset values
    localparam logic [3:0] C_BRNCH = 4'b1111;  // taken branch in RUN

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REG_W-1:0]  id_src1, id_src2, ex_dest, mem_dest;
    logic              id_rd_act, ex_wr, ex_is_load, mem_wr, br_taken, perf_clr;
    logic              pc_we, ifid_we, idex_bubble, ifid_flush;
    logic [PERF_W-1:0] stall_cycles;
    logic [3:0]        w_outs;

    int nCompared = 0;
    int nMismatch = 0;

    pipe_stall_controller #(
        .REG_W  (REG_W),
        .CNT_W  (CNT_W),
        .PERF_W (PERF_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_rd_act    (id_rd_act),
        .ex_dest      (ex_dest),
        .ex_wr        (ex_wr),
        .ex_is_load   (ex_is_load),
        .mem_dest     (mem_dest),
        .mem_wr       (mem_wr),
        .br_taken     (br_taken),
        .perf_clr     (perf_clr),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .idex_bubble  (idex_bubble),
        .ifid_flush   (ifid_flush),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    assign w_outs = {pc_we, ifid_we, idex_bubble, ifid_flush};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_src1 = '0; id_src2 = '0; id_rd_act = 1'b0;
        ex_dest = '0; ex_wr = 1'b0; ex_is_load = 1'b0;
        mem_dest = '0; mem_wr = 1'b0; br_taken = 1'b0; perf_clr = 1'b0;
    endtask

    // EX-stage hit on src1 = r3; flagged as a load so it also stalls with bypass.
    task automatic exHazard();
        id_src1 = 4'd3; id_rd_act = 1'b1; ex_dest = 4'd3; ex_wr = 1'b1; ex_is_load = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #2;
        nCompared++;
        if (w_outs !== C_HOLD) begin
            nMismatch++; $display("FAIL reset_outs: got %b want %b", w_outs, C_HOLD);
        end
        nCompared++;
        if (stall_cycles !== 16'd0) begin
            nMismatch++; $display("FAIL reset_perf: got %0d want 0", stall_cycles);
        end
        tick(); tick();
        rst_n = 1'b1;
        #1;
        nCompared++;
        if (w_outs !== C_RUN) begin
            nMismatch++; $display("FAIL reset_release_outs: got %b want %b", w_outs, C_RUN);
        end
        tick();
    endtask

`ifndef FORWARDING_EN
    task automatic test_ex_stall();
        idle();
        exHazard();
        ex_is_load = 1'b0;
        #1;
        nCompared++;
        if (w_outs !== C_HOLD) begin
            nMismatch++; $display("FAIL ex_stall_c0: got %b want %b", w_outs, C_HOLD);
        end
        tick();
        idle();  // STALL must not look at the inputs
        #1;
        nCompared++;
        if (w_outs !== C_HOLD) begin
            nMismatch++; $display("FAIL ex_stall_c1: got %b want %b", w_outs, C_HOLD);
        end
        tick();
        nCompared++;
        if (w_outs !== C_RUN) begin
            nMismatch++; $display("FAIL ex_stall_c2: got %b want %b", w_outs, C_RUN);
        end
        nCompared++;
        if (stall_cycles !== 16'd2) begin
            nMismatch++; $display("FAIL ex_stall_perf: got %0d want 2", stall_cycles);
        end
    endtask

    task automatic test_mem_stall();
        idle();
        id_src2 = 4'd5; id_rd_act = 1'b1; mem_dest = 4'd5; mem_wr = 1'b1;
        #1;
        nCompared++;
        if (w_outs !== C_HOLD) begin
            nMismatch++; $display("FAIL mem_stall_c0: got %b want %b", w_outs, C_HOLD);
        end
        tick();
        idle();
        #1;
        nCompared++;
        if (w_outs !== C_RUN) begin
            nMismatch++; $display("FAIL mem_stall_c1: got %b want %b", w_outs, C_RUN);
        end
        nCompared++;
        if (stall_cycles !== 16'd3) begin
            nMismatch++; $display("FAIL mem_stall_perf: got %0d want 3", stall_cycles);
        end
        // r0 never hazards.
        id_src1 = 4'd0; id_rd_act = 1'b1; ex_dest = 4'd0; ex_wr = 1'b1;
        #1;
        nCompared++;
        if (w_outs !== C_RUN) begin
            nMismatch++; $display("FAIL reg_zero: got %b want %b", w_outs, C_RUN);
        end
        // Matching register but sources not read.
        id_src1 = 4'd7; ex_dest = 4'd7; id_rd_act = 1'b0;
        #1;
        nCompared++;
        if (w_outs !== C_RUN) begin
            nMismatch++; $display("FAIL no_rd_act: got %b want %b", w_outs, C_RUN);
        end
        tick();
        idle();
    endtask
`else
    task automatic test_forwarding();
        idle();
        exHazard();
        ex_is_load = 1'b0;
        #1;
        nCompared++;
        if (w_outs !== C_RUN) begin
            nMismatch++; $display("FAIL fwd_ex_alu: got %b want %b", w_outs, C_RUN);
        end
        ex_is_load = 1'b1;
        #1;
        nCompared++;
        if (w_outs !== C_HOLD) begin
            nMismatch++; $display("FAIL fwd_load_c0: got %b want %b", w_outs, C_HOLD);
        end
        tick();
        idle();
        #1;
        nCompared++;
        if (w_outs !== C_RUN) begin
            nMismatch++; $display("FAIL fwd_load_c1: got %b want %b", w_outs, C_RUN);
        end
        id_src2 = 4'd5; id_rd_act = 1'b1; mem_dest = 4'd5; mem_wr = 1'b1;
        #1;
        nCompared++;
        if (w_outs !== C_RUN) begin
            nMismatch++; $display("FAIL fwd_mem: got %b want %b", w_outs, C_RUN);
        end
        tick();
        idle();
    endtask
`endif

    task automatic test_branch();
        idle();
        exHazard();
        br_taken = 1'b1;
        #1;
        nCompared++;
        if (w_outs !== C_BRNCH) begin
            nMismatch++; $display("FAIL branch_c0: got %b want %b", w_outs, C_BRNCH);
        end
        tick();
        br_taken = 1'b0;  // hazard still matches but FLUSH masks it
        #1;
        nCompared++;
        if (w_outs !== C_RUN) begin
            nMismatch++; $display("FAIL branch_flush: got %b want %b", w_outs, C_RUN);
        end
        idle();
        tick();
        nCompared++;
        if (w_outs !== C_RUN) begin
            nMismatch++; $display("FAIL branch_after: got %b want %b", w_outs, C_RUN);
        end
    endtask

    task automatic test_reset_mid_stall();
        idle();
        exHazard();
        tick();  // stalling (STALL without bypass)
        rst_n = 1'b0;
        #1;
        nCompared++;
        if (w_outs !== C_HOLD) begin
            nMismatch++; $display("FAIL rst_mid_outs: got %b want %b", w_outs, C_HOLD);
        end
        nCompared++;
        if (stall_cycles !== 16'd0) begin
            nMismatch++; $display("FAIL rst_mid_perf: got %0d want 0", stall_cycles);
        end
        idle();
        tick();
        rst_n = 1'b1;
        #1;
        nCompared++;
        if (w_outs !== C_RUN) begin
            nMismatch++; $display("FAIL rst_mid_release: got %b want %b", w_outs, C_RUN);
        end
        tick();
        nCompared++;
        if (w_outs !== C_RUN || stall_cycles !== 16'd0) begin
            nMismatch++;
            $display("FAIL rst_mid_run: got %b/%0d want %b/0", w_outs, stall_cycles, C_RUN);
        end
    endtask

    task automatic test_perf_saturate();
        idle();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        exHazard();  // held continuously: every cycle has pc_we=0
        repeat (65535) tick();
        nCompared++;
        if (stall_cycles !== 16'hFFFF) begin
            nMismatch++; $display("FAIL perf_full: got %h want ffff", stall_cycles);
        end
        repeat (3) tick();
        nCompared++;
        if (stall_cycles !== 16'hFFFF) begin
            nMismatch++; $display("FAIL perf_hold: got %h want ffff", stall_cycles);
        end
        perf_clr = 1'b1;
        #1;
        nCompared++;
        if (pc_we !== 1'b0) begin
            nMismatch++; $display("FAIL perf_clr_in_stall: pc_we got %b want 0", pc_we);
        end
        tick();
        perf_clr = 1'b0;
        nCompared++;
        if (stall_cycles !== 16'd0) begin
            nMismatch++; $display("FAIL perf_clr: got %h want 0", stall_cycles);
        end
        idle();
        tick(); tick();
        nCompared++;
        if (w_outs !== C_RUN) begin
            nMismatch++; $display("FAIL perf_end_run: got %b want %b", w_outs, C_RUN);
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
`ifndef FORWARDING_EN
        test_ex_stall();
        test_mem_stall();
`else
        test_forwarding();
`endif
        test_branch();
        test_reset_mid_stall();
        test_perf_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule : tb_pipe_stall_controller

`default_nettype wire
